motion_estimator: RTL and testbench



---
 rtl/me_pkg.sv | 14 +
 rtl/me_pe.sv | 51 +++++
 rtl/motion_estimator.sv | 126 ++++++++++++
 tb/tb_motion_estimator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and types for the full-search block-matching motion estimator.
package me_pkg;
   localparam int BLK      = 16;
   localparam int WIN      = 31;
   localparam int NPE      = 16;
   localparam int PASS_LEN = 272;
   localparam int SAD_W    = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction
endpackage

// File: rtl/me_pe.sv
// One processing element: accumulates the SAD of a single horizontal offset dx=K
// over one 272-cycle pass, using R delayed by K cycles and the matching search byte.
module me_pe
   import me_pkg::*;
#(
   parameter int K = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             active,
   input  logic [7:0]       r_in,
   input  logic [7:0]       s1,
   input  logic [7:0]       s2,
   input  logic [8:0]       t,
   output logic [SAD_W-1:0] acc
);
   localparam logic [8:0] T_LOAD = 9'(K);
   localparam logic [8:0] T_LAST = 9'(255 + K);

   logic [7:0] r_dly;
   logic [4:0] col_k;
   logic [7:0] s_sel;
   logic [7:0] diff;

   if (K == 0) begin : g_direct
      assign r_dly = r_in;
   end else begin : g_shift
      logic [7:0] sr [K];
      always_ff @(posedge clock) begin
         sr[0] <= r_in;
         for (int i = 1; i < K; i++) sr[i] <= sr[i-1];
      end
      assign r_dly = sr[K-1];
   end

   // col+16-K carries into bit 4 exactly when col>=K, i.e. the pixel is still on the s1 row
   assign col_k = {1'b0, t[3:0]} + 5'(16 - K);
   assign s_sel = col_k[4] ? s1 : s2;
   assign diff  = abs_diff(r_dly, s_sel);

   always_ff @(posedge clock) begin
      if (reset) begin
         acc <= '0;
      end else if (active) begin
         if (t == T_LOAD)
            acc <= SAD_W'(diff);
         else if (t > T_LOAD && t <= T_LAST)
            acc <= acc + SAD_W'(diff);
      end
   end
endmodule

// File: rtl/motion_estimator.sv
// Full-search motion estimator: 16 passes over dy, 16 PEs cover dx in parallel,
// comparator keeps the first strict minimum; result published one cycle after the last pass.
module motion_estimator
   import me_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  R,
   input  logic [7:0]  s1,
   input  logic [7:0]  s2,
   output logic [7:0]  AddressR,
   output logic [9:0]  AddressS1,
   output logic [9:0]  AddressS2,
   output logic [3:0]  motionx,
   output logic [3:0]  motiony,
   output logic [15:0] best_dist,
   output logic        done
);
   localparam logic [8:0] T_END = 9'(PASS_LEN - 1);

   state_t           state, next_state;
   logic [3:0]       dy;
   logic [8:0]       t;
   logic             pass_end, last_cycle, enter_run, running;
   logic [5:0]       ysum;
   logic [SAD_W-1:0] acc [NPE];
   logic [SAD_W-1:0] best, cand;
   logic [3:0]       best_dx, best_dy;

   assign running    = (state == RUN);
   assign pass_end   = (t == T_END);
   assign last_cycle = running && pass_end && (dy == 4'hF);
   assign enter_run  = (state != RUN) && (next_state == RUN);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // DONE only re-arms once the result is visible, so a held start still shows done for a cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_cycle) next_state = DONE;
         DONE:    if (start && done) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || enter_run) begin
         dy <= '0;
         t  <= '0;
      end else if (running) begin
         if (pass_end) begin
            t  <= '0;
            dy <= dy + 4'd1;
         end else begin
            t <= t + 9'd1;
         end
      end
   end

   assign ysum = {2'b00, dy} + {1'b0, t[8:4]};

   always_comb begin
      AddressR  = '0;
      AddressS1 = '0;
      AddressS2 = '0;
      if (running) begin
         AddressR = t[7:0];
         if (ysum <= 6'd30) AddressS1 = 10'(ysum) * 10'd31 + 10'(t[3:0]);
         if (ysum != 6'd0)  AddressS2 = 10'(ysum - 6'd1) * 10'd31 + 10'(t[3:0]) + 10'd16;
      end
   end

   for (genvar k = 0; k < NPE; k++) begin : g_pe
      me_pe #(.K(k)) u_pe (
         .clock  (clock),
         .reset  (reset),
         .active (running),
         .r_in   (R),
         .s1     (s1),
         .s2     (s2),
         .t      (t),
         .acc    (acc[k])
      );
   end

   // PE k finishes at t=255+k, so t=256..271 visits the PEs in dx order
   assign cand = acc[t[3:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         best    <= '1;
         best_dx <= '0;
         best_dy <= '0;
      end else if (enter_run) begin
         best    <= '1;
         best_dx <= '0;
         best_dy <= '0;
      end else if (running && t[8] && cand < best) begin
         best    <= cand;
         best_dx <= t[3:0];
         best_dy <= dy;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         motionx   <= '0;
         motiony   <= '0;
         best_dist <= '0;
         done      <= 1'b0;
      end else if (enter_run) begin
         done <= 1'b0;
      end else if (state == DONE && !done) begin
         motionx   <= best_dx ^ 4'h8;
         motiony   <= best_dy ^ 4'h8;
         best_dist <= best;
         done      <= 1'b1;
      end
   end
endmodule

// File: tb/tb_motion_estimator.sv
// Self-checking bench: directed table plus randomized frames against a plain-arithmetic SAD model.
module tb_motion_estimator;
   logic        clock = 1'b0;
   logic        reset, start;
   logic [7:0]  R, s1, s2, AddressR;
   logic [9:0]  AddressS1, AddressS2;
   logic [3:0]  motionx, motiony;
   logic [15:0] best_dist;
   logic        done;

   always #5 clock = ~clock;

   motion_estimator dut (
      .clock(clock), .reset(reset), .start(start),
      .R(R), .s1(s1), .s2(s2),
      .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
      .motionx(motionx), .motiony(motiony), .best_dist(best_dist), .done(done)
   );

   logic [7:0] mem_r [256];
   logic [7:0] mem_s [961];

   always_comb begin
      R  = mem_r[AddressR];
      s1 = 8'h00;
      s2 = 8'h00;
      if (AddressS1 < 10'd961) s1 = mem_s[AddressS1];
      if (AddressS2 < 10'd961) s2 = mem_s[AddressS2];
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // kind 0: ramp R planted in 0xFF search; 1: all zero; 2: R=0x10,S=0; 3: random; 4: random + planted R
   task automatic fill(input int kind, input int pdx, input int pdy);
      for (int i = 0; i < 961; i++)
         case (kind)
            0:       mem_s[i] = 8'hFF;
            1, 2:    mem_s[i] = 8'h00;
            default: mem_s[i] = 8'($urandom);
         endcase
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            case (kind)
               0:       mem_r[r*16+c] = 8'(r*16 + c + 1);
               1:       mem_r[r*16+c] = 8'h00;
               2:       mem_r[r*16+c] = 8'h10;
               default: mem_r[r*16+c] = 8'($urandom);
            endcase
            if (kind == 0 || kind == 4) mem_s[(r+pdy)*31 + c + pdx] = mem_r[r*16+c];
         end
   endtask

   task automatic ref_model(output logic [3:0] mx, output logic [3:0] my, output logic [15:0] bd);
      int best = 1 << 30;
      int sad, d;
      mx = 0; my = 0;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) begin
            sad = 0;
            for (int r = 0; r < 16; r++)
               for (int c = 0; c < 16; c++) begin
                  d = int'(mem_r[r*16+c]) - int'(mem_s[(r+y)*31 + c + x]);
                  sad += (d < 0) ? -d : d;
               end
            if (sad < best) begin
               best = sad;
               mx = 4'(x - 8);
               my = 4'(y - 8);
            end
         end
      bd = 16'(best);
   endtask

   task automatic check_addr(input int tt);
      int row = tt / 16;
      int col = tt % 16;
      check($sformatf("addr_r_t%0d", tt), 32'(AddressR), 32'(tt % 256));
      check($sformatf("addr_s1_t%0d", tt), 32'(AddressS1), (row <= 30) ? 32'(row*31 + col) : 0);
      check($sformatf("addr_s2_t%0d", tt), 32'(AddressS2), (row >= 1) ? 32'((row-1)*31 + col + 16) : 0);
   endtask

   // Called #1 after the edge that sampled start; returns edges counted until done is seen.
   task automatic wait_done(input bit addr_chk, output int n);
      n = 0;
      while (done !== 1'b1 && n < 6000) begin
         if (addr_chk && (n == 0 || n == 17 || n == 256)) check_addr(n);
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic pulse_and_wait(input bit addr_chk, output int n);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(addr_chk, n);
   endtask

   task automatic check_result(input string tag, input logic [3:0] mx, input logic [3:0] my, input logic [15:0] bd);
      check({tag, "_motionx"}, 32'(motionx), 32'(mx));
      check({tag, "_motiony"}, 32'(motiony), 32'(my));
      check({tag, "_best_dist"}, 32'(best_dist), 32'(bd));
   endtask

   typedef struct {
      int         kind;
      int         pdx;
      int         pdy;
      logic [3:0] mx;
      logic [3:0] my;
      logic [15:0] bd;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int n;
      logic [3:0] emx, emy;
      logic [15:0] ebd;

      tbl[0] = '{0, 11, 4, 4'h3, 4'hC, 16'd0};
      tbl[1] = '{1, 0, 0, 4'h8, 4'h8, 16'd0};
      tbl[2] = '{2, 0, 0, 4'h8, 4'h8, 16'd4096};
      tbl[3] = '{0, 15, 15, 4'h7, 4'h7, 16'd0};

      reset = 1'b1;
      start = 1'b0;
      fill(1, 0, 0);
      repeat (3) @(posedge clock);
      #1;
      check("reset_done", 32'(done), 0);
      check_result("reset", 4'h0, 4'h0, 16'h0);
      check("reset_addr_s1", 32'(AddressS1), 0);
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 4; i++) begin
         fill(tbl[i].kind, tbl[i].pdx, tbl[i].pdy);
         pulse_and_wait(i == 0, n);
         check($sformatf("tbl%0d_latency", i), 32'(n), 32'd4353);
         check_result($sformatf("tbl%0d", i), tbl[i].mx, tbl[i].my, tbl[i].bd);
         repeat (2) @(posedge clock);
         #1;
      end

      // reset partway through a run
      fill(0, 11, 4);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (1000) @(posedge clock);
      #1;
      check("midrun_busy_done", 32'(done), 0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midrun_reset_done", 32'(done), 0);
      check_result("midrun_reset", 4'h0, 4'h0, 16'h0);
      check("midrun_reset_addr_r", 32'(AddressR), 0);
      check("midrun_reset_addr_s1", 32'(AddressS1), 0);
      check("midrun_reset_addr_s2", 32'(AddressS2), 0);
      @(posedge clock); #1;
      pulse_and_wait(1'b0, n);
      check("after_reset_latency", 32'(n), 32'd4353);
      check_result("after_reset", 4'h3, 4'hC, 16'd0);

      // start held high across completion reruns and reproduces the result
      fill(0, 15, 15);
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      wait_done(1'b0, n);
      check("held1_latency", 32'(n), 32'd4353);
      check_result("held1", 4'h7, 4'h7, 16'd0);
      @(posedge clock); #1;
      check("held_rerun_done_low", 32'(done), 0);
      wait_done(1'b0, n);
      check("held2_latency", 32'(n), 32'd4353);
      check_result("held2", 4'h7, 4'h7, 16'd0);
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("held_idle_done", 32'(done), 1);
      check_result("held_stable", 4'h7, 4'h7, 16'd0);

      for (int i = 0; i < 3; i++) begin
         fill((i == 0) ? 3 : 4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         ref_model(emx, emy, ebd);
         pulse_and_wait(1'b0, n);
         check($sformatf("rand%0d_latency", i), 32'(n), 32'd4353);
         check_result($sformatf("rand%0d", i), emx, emy, ebd);
         @(posedge clock); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
